// File: rtl/ps2_cmd_scheduler_pkg.sv
// PS/2 host command scheduler: shared byte constants, FSM states
// and the script ROM entry layout.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_LED       = 8'hED;
  localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_RESEND    = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL  = 8'hFC;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_TX,
    S_WAIT_RSP,
    S_READ,
    S_EVAL,
    S_WAIT_BAT,
    S_ERR
  } state_e;

  typedef enum logic {
    SCR_INIT,
    SCR_LED
  } script_e;

  typedef struct packed {
    logic [7:0] data;
    logic       expect_bat;
    logic       last;
  } script_t;

endpackage

// File: rtl/ps2_cmd_scheduler_if.sv
// PS/2 tx/rx port bundle seen by the command scheduler;
// master is the scheduler, slave is the ps2tx/ps2rx/decoder side.
interface ps2_cmd_scheduler_if;
  logic       tx_wren;
  logic [7:0] tx_d;
  logic       tx_busy;
  logic       rx_dsr;
  logic [7:0] rx_q;
  logic       rx_rden;
  logic       key_dsr;
  logic       key_rden;

  modport master (
    output tx_wren, tx_d, rx_rden, key_dsr,
    input  tx_busy, rx_dsr, rx_q, key_rden
  );

  modport slave (
    input  tx_wren, tx_d, rx_rden, key_dsr,
    output tx_busy, rx_dsr, rx_q, key_rden
  );
endinterface

// File: rtl/ps2_cmd_scheduler_script.sv
// Command script ROM: {script, step} -> byte to send plus
// whether a BAT wait follows and whether it ends the script.
module ps2_cmd_script
  import ps2_pkg::*;
#(
  parameter logic [7:0] TYPEMATIC = 8'h20
) (
  input  script_e    sel,
  input  logic [2:0] step,
  input  logic [2:0] led_state,
  output script_t    ent
);

  logic [7:0] led_byte;
  assign led_byte = {5'b0, led_state};

  always_comb begin
    ent = '{data: led_byte, expect_bat: 1'b0, last: 1'b1};
    if (sel == SCR_INIT) begin
      case (step)
        3'd0: ent = '{data: CMD_RESET, expect_bat: 1'b1, last: 1'b0};
        3'd1: ent = '{data: CMD_TYPEMATIC, expect_bat: 1'b0, last: 1'b0};
        3'd2: ent = '{data: TYPEMATIC, expect_bat: 1'b0, last: 1'b0};
        3'd3: ent = '{data: CMD_LED, expect_bat: 1'b0, last: 1'b0};
        default: ent = '{data: led_byte, expect_bat: 1'b0, last: 1'b1};
      endcase
    end else begin
      case (step)
        3'd0: ent = '{data: CMD_LED, expect_bat: 1'b0, last: 1'b0};
        default: ent = '{data: led_byte, expect_bat: 1'b0, last: 1'b1};
      endcase
    end
  end

endmodule

// File: rtl/ps2_cmd_scheduler.sv
// Sequences host-to-keyboard PS/2 commands (reset/BAT, typematic,
// LEDs), owns ps2tx and hides protocol replies from the decoder.
module ps2_cmd_scheduler
  import ps2_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 240000,
  parameter int         BAT_CYCLES     = 24000000,
  parameter int         MAX_RETRY      = 3,
  parameter logic [7:0] TYPEMATIC      = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_req,
  input  logic                 led_update,
  input  logic [2:0]           led_state,
  ps2_cmd_scheduler_if.master  bus,
  output logic                 busy,
  output logic                 err
);

  localparam int TW = $clog2(BAT_CYCLES);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] BAT_LAST = TW'(BAT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_e        state_q, state_d;
  script_e       sel_q, sel_d;
  logic [2:0]    step_q, step_d;
  logic [7:0]    tx_d_q, tx_d_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    rsp_q, rsp_d;
  logic          in_bat_q, in_bat_d;
  logic          pend_init_q, pend_init_d;
  logic          pend_led_q, pend_led_d;
  logic          err_q, err_d;
  logic          resend;
  logic          idle;
  script_t       ent;

  ps2_cmd_script #(
    .TYPEMATIC(TYPEMATIC)
  ) u_script (
    .sel      (sel_q),
    .step     (step_q),
    .led_state(led_state),
    .ent      (ent)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    step_d      = step_q;
    tx_d_d      = tx_d_q;
    retry_d     = retry_q;
    rsp_d       = rsp_q;
    in_bat_d    = in_bat_q;
    pend_init_d = pend_init_q;
    pend_led_d  = pend_led_q;
    err_d       = err_q;
    resend      = 1'b0;
    timer_d     = (state_q == S_IDLE) ? '0 : timer_q + TW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (pend_init_q) begin
          sel_d       = SCR_INIT;
          step_d      = 3'd0;
          pend_init_d = 1'b0;
          pend_led_d  = 1'b0;
          err_d       = 1'b0;
          state_d     = S_LOAD;
        end else if (pend_led_q) begin
          sel_d      = SCR_LED;
          step_d     = 3'd0;
          pend_led_d = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_d_d   = ent.data;
        retry_d  = '0;
        in_bat_d = 1'b0;
        state_d  = S_SEND;
      end
      S_SEND: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (!bus.tx_busy) begin
          timer_d = '0;
          state_d = S_WAIT_RSP;
        end
      end
      // Timer keeps running across READ/EVAL of discarded bytes,
      // hence >= rather than an exact match.
      S_WAIT_RSP: begin
        if (bus.rx_dsr) state_d = S_READ;
        else if (timer_q >= TO_LAST) resend = 1'b1;
      end
      S_WAIT_BAT: begin
        if (bus.rx_dsr) state_d = S_READ;
        else if (timer_q >= BAT_LAST) state_d = S_ERR;
      end
      S_READ: begin
        rsp_d   = bus.rx_q;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (in_bat_q) begin
          if (rsp_q == RSP_BAT_OK) begin
            step_d  = step_q + 3'd1;
            state_d = S_LOAD;
          end else if (rsp_q == RSP_BAT_FAIL) begin
            state_d = S_ERR;
          end else begin
            state_d = S_WAIT_BAT;
          end
        end else if (rsp_q == RSP_ACK) begin
          if (ent.expect_bat) begin
            in_bat_d = 1'b1;
            timer_d  = '0;
            state_d  = S_WAIT_BAT;
          end else if (ent.last) begin
            state_d = S_IDLE;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_LOAD;
          end
        end else if (rsp_q == RSP_RESEND) begin
          resend = 1'b1;
        end else begin
          state_d = S_WAIT_RSP;
        end
      end
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (resend) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RW'(1);
        state_d = S_SEND;
      end else begin
        state_d = S_ERR;
      end
    end

    // Set after the IDLE clears so a same-cycle pulse is kept.
    pend_init_d = pend_init_d | init_req;
    pend_led_d  = pend_led_d | led_update;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= SCR_INIT;
      step_q      <= '0;
      tx_d_q      <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      rsp_q       <= '0;
      in_bat_q    <= 1'b0;
      pend_init_q <= 1'b1;
      pend_led_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      step_q      <= step_d;
      tx_d_q      <= tx_d_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      rsp_q       <= rsp_d;
      in_bat_q    <= in_bat_d;
      pend_init_q <= pend_init_d;
      pend_led_q  <= pend_led_d;
      err_q       <= err_d;
    end
  end

  assign idle        = (state_q == S_IDLE);
  assign bus.tx_wren = ~reset & (state_q == S_SEND);
  assign bus.tx_d    = tx_d_q;
  assign bus.rx_rden = ~reset & (idle ? bus.key_rden : (state_q == S_READ));
  assign bus.key_dsr = ~reset & idle & bus.rx_dsr;
  assign busy        = ~idle | pend_init_q | pend_led_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Directed bench for ps2_cmd_scheduler with a small keyboard,
// ps2tx and ps2rx model driven on the falling clock edge.
module tb_ps2_cmd_scheduler;

  localparam int TO   = 40;
  localparam int BAT  = 200;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_req = 1'b0;
  logic       led_update = 1'b0;
  logic [2:0] led_state = 3'b000;
  logic       busy;
  logic       err;

  ps2_cmd_scheduler_if bus ();

  ps2_cmd_scheduler #(
    .TIMEOUT_CYCLES(TO),
    .BAT_CYCLES    (BAT),
    .MAX_RETRY     (MAXR),
    .TYPEMATIC     (8'h20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_req  (init_req),
    .led_update(led_update),
    .led_state (led_state),
    .bus       (bus),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [7:0]  rxq[$];
  logic [15:0] plan[$];
  logic [7:0]  txlog[$];
  int          txtime[$];
  logic [7:0]  exp_log[$];
  logic [15:0] cur_plan;
  int          cyc;
  int          busy_cnt;
  bit          pop_pend;
  bit          key_seen;
  int          n_chk = 0;
  int          n_err = 0;

  // Keyboard model: each sent byte pops one plan entry
  // {second reply, first reply}; 00 means no reply.
  initial begin
    bus.tx_busy  = 1'b0;
    bus.rx_dsr   = 1'b0;
    bus.rx_q     = 8'h00;
    bus.key_rden = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    pop_pend = 0;
    key_seen = 0;
    cur_plan = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rxq.delete();
        busy_cnt = 0;
        pop_pend = 0;
      end else begin
        if (pop_pend && rxq.size() > 0) void'(rxq.pop_front());
        pop_pend = bus.rx_rden && bus.rx_dsr;
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            if (cur_plan[7:0] != 8'h00) rxq.push_back(cur_plan[7:0]);
            if (cur_plan[15:8] != 8'h00) rxq.push_back(cur_plan[15:8]);
          end
        end
        if (bus.tx_wren) begin
          txlog.push_back(bus.tx_d);
          txtime.push_back(cyc);
          busy_cnt = 4;
          cur_plan = (plan.size() > 0) ? plan.pop_front() : 16'h0000;
        end
        if (bus.key_dsr) key_seen = 1;
      end
      bus.tx_busy = (busy_cnt > 0);
      bus.rx_dsr  = (rxq.size() > 0);
      bus.rx_q    = (rxq.size() > 0) ? rxq[0] : 8'h00;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int byte_at(input int i);
    return (txlog.size() > i) ? int'(txlog[i]) : -1;
  endfunction

  task automatic check_log(input string tag);
    check_eq({tag, "_len"}, txlog.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), byte_at(i), {24'h0, exp_log[i]});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    plan.delete();
    txlog.delete();
    txtime.delete();
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic pulse_led();
    led_update = 1'b1;
    step();
    led_update = 1'b0;
  endtask

  initial begin
    int n;
    int gap;

    // Reset values and automatic init
    reset = 1'b1;
    step();
    check_eq("rst_tx_wren", bus.tx_wren, 1'b0);
    check_eq("rst_tx_d", bus.tx_d, 8'h00);
    check_eq("rst_rx_rden", bus.rx_rden, 1'b0);
    check_eq("rst_key_dsr", bus.key_dsr, 1'b0);
    check_eq("rst_busy", busy, 1'b1);
    check_eq("rst_err", err, 1'b0);
    step();
    plan = '{16'hAAFA, 16'h00FA, 16'h00FA, 16'h00FA, 16'h00FA};
    reset = 1'b0;
    wait_idle("t1_done", 3000);
    exp_log = '{8'hFF, 8'hF3, 8'h20, 8'hED, 8'h00};
    check_log("t1");
    check_eq("t1_err", err, 1'b0);
    check_eq("t1_key_dsr_seen", key_seen, 1'b0);

    // LED update plus decoder passthrough in IDLE
    txlog.delete();
    led_state = 3'b100;
    plan = '{16'h00FA, 16'h00FA};
    pulse_led();
    wait_idle("t2_done", 1000);
    exp_log = '{8'hED, 8'h04};
    check_log("t2");
    check_eq("t2_err", err, 1'b0);
    rxq.push_back(8'h1C);
    step();
    check_eq("t2_pt_dsr", bus.key_dsr, 1'b1);
    bus.key_rden = 1'b1;
    #1;
    check_eq("t2_pt_rden", bus.rx_rden, 1'b1);
    step();
    bus.key_rden = 1'b0;
    step();
    step();
    check_eq("t2_pt_dsr_clr", bus.key_dsr, 1'b0);

    // Two resend requests on ED
    txlog.delete();
    plan = '{16'h00FE, 16'h00FE, 16'h00FA, 16'h00FA};
    pulse_led();
    wait_idle("t3_done", 1000);
    exp_log = '{8'hED, 8'hED, 8'hED, 8'h04};
    check_log("t3");
    check_eq("t3_err", err, 1'b0);

    // Silent keyboard: timeouts exhaust the retries
    txlog.delete();
    txtime.delete();
    pulse_led();
    wait_idle("t4_done", 2000);
    exp_log = '{8'hED, 8'hED, 8'hED, 8'hED};
    check_log("t4");
    check_eq("t4_err", err, 1'b1);
    for (int i = 1; i < txtime.size(); i++) begin
      gap = txtime[i] - txtime[i-1];
      check_eq($sformatf("t4_gap%0d", i), (gap >= TO && gap <= TO + 10), 1'b1);
    end

    // BAT failure, then init_req clears err and resends FF
    led_state = 3'b000;
    do_reset();
    plan = '{16'hFCFA};
    wait_idle("t5_fail_done", 1000);
    check_eq("t5_err", err, 1'b1);
    exp_log = '{8'hFF};
    check_log("t5a");
    txlog.delete();
    plan = '{16'hAAFA, 16'h00FA, 16'h00FA, 16'h00FA, 16'h00FA};
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    step();
    step();
    check_eq("t5_err_clr", err, 1'b0);
    wait_idle("t5_done", 3000);
    exp_log = '{8'hFF, 8'hF3, 8'h20, 8'hED, 8'h00};
    check_log("t5b");
    check_eq("t5_err_end", err, 1'b0);

    // Three LED pulses during init collapse into one update
    led_state = 3'b001;
    do_reset();
    plan = '{16'hAAFA, 16'h00FA, 16'h00FA, 16'h00FA, 16'h00FA,
             16'h00FA, 16'h00FA};
    repeat (3) begin
      step();
      step();
      pulse_led();
    end
    n = 0;
    while (txlog.size() < 5 && n < 1000) begin
      step();
      n++;
    end
    check_eq("t6_init_sent", txlog.size() >= 5, 1'b1);
    led_state = 3'b110;
    wait_idle("t6_done", 2000);
    exp_log = '{8'hFF, 8'hF3, 8'h20, 8'hED, 8'h01, 8'hED, 8'h06};
    check_log("t6");
    check_eq("t6_err", err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
